// File: rtl/matmul_operand_loader_if.sv
// Stream-in / tile-out bundle for the matmul operand loader.
// master = beat producer plus tile consumer; slave = the loader itself.
interface matmul_operand_loader_if #(
  parameter int unsigned M = 2,
  parameter int unsigned N = 2,
  parameter int unsigned K = 2,
  parameter int unsigned P = 8
);
  logic [4*P-1:0]        data_in;
  logic                  valid_in;
  logic                  last_in;
  logic                  ready_in;
  logic signed [P-1:0]   A [M][K];
  logic signed [P-1:0]   B [K][N];
  logic signed [4*P-1:0] C [M][N];
  logic                  valid_out;
  logic                  ready_out;
  logic                  frame_err;

  modport master (
    output data_in, valid_in, last_in, ready_out,
    input  ready_in, A, B, C, valid_out, frame_err
  );

  modport slave (
    input  data_in, valid_in, last_in, ready_out,
    output ready_in, A, B, C, valid_out, frame_err
  );
endinterface

// File: rtl/matmul_operand_loader.sv
// Assembles A, B and C tiles from a beat stream (A then B then C, row-major)
// and holds the complete, single-buffered frame until downstream accepts it.
module matmul_operand_loader #(
  parameter int unsigned M = 2,
  parameter int unsigned N = 2,
  parameter int unsigned K = 2,
  parameter int unsigned P = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  matmul_operand_loader_if.slave  bus
);
  localparam int unsigned IW = $clog2(M + N + K + 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_C, PRESENT} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         row_q, row_d, col_q, col_d;
  logic [IW-1:0]         rows_m1, cols_m1;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  accept, last_elem;
  logic signed [P-1:0]   a_q [M][K], a_d [M][K];
  logic signed [P-1:0]   b_q [K][N], b_d [K][N];
  logic signed [4*P-1:0] c_q [M][N], c_d [M][N];

  always_comb begin
    rows_m1 = IW'(M - 1);
    cols_m1 = IW'(K - 1);
    case (state_q)
      LOAD_B: begin
        rows_m1 = IW'(K - 1);
        cols_m1 = IW'(N - 1);
      end
      LOAD_C: begin
        rows_m1 = IW'(M - 1);
        cols_m1 = IW'(N - 1);
      end
      default: ;
    endcase

    accept    = bus.valid_in && ready_q;
    last_elem = (row_q == rows_m1) && (col_q == cols_m1);

    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;

    if (state_q == PRESENT) begin
      if (valid_q && bus.ready_out) begin
        state_d = LOAD_A;
        valid_d = 1'b0;
        row_d   = '0;
        col_d   = '0;
      end
    end else if (accept) begin
      // An early last_in aborts before its beat is stored.
      if (bus.last_in && !(state_q == LOAD_C && last_elem)) begin
        err_d   = 1'b1;
        state_d = LOAD_A;
        row_d   = '0;
        col_d   = '0;
      end else begin
        for (int unsigned i = 0; i < M; i++)
          for (int unsigned j = 0; j < K; j++)
            if (state_q == LOAD_A && row_q == IW'(i) && col_q == IW'(j))
              a_d[i][j] = bus.data_in[P-1:0];
        for (int unsigned i = 0; i < K; i++)
          for (int unsigned j = 0; j < N; j++)
            if (state_q == LOAD_B && row_q == IW'(i) && col_q == IW'(j))
              b_d[i][j] = bus.data_in[P-1:0];
        for (int unsigned i = 0; i < M; i++)
          for (int unsigned j = 0; j < N; j++)
            if (state_q == LOAD_C && row_q == IW'(i) && col_q == IW'(j))
              c_d[i][j] = bus.data_in;

        if (last_elem) begin
          row_d = '0;
          col_d = '0;
          case (state_q)
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = LOAD_C;
            default: begin
              if (bus.last_in) begin
                state_d = PRESENT;
                valid_d = 1'b1;
              end else begin
                err_d   = 1'b1;
                state_d = LOAD_A;
              end
            end
          endcase
        end else if (col_q == cols_m1) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end

    ready_d = (state_d != PRESENT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= LOAD_A;
      row_q   <= '0;
      col_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < M; i++)
        for (int unsigned j = 0; j < K; j++)
          a_q[i][j] <= '0;
      for (int unsigned i = 0; i < K; i++)
        for (int unsigned j = 0; j < N; j++)
          b_q[i][j] <= '0;
      for (int unsigned i = 0; i < M; i++)
        for (int unsigned j = 0; j < N; j++)
          c_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign bus.ready_in  = ready_q;
  assign bus.valid_out = valid_q;
  assign bus.frame_err = err_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.C         = c_q;
endmodule
